sevseg_scan: RTL
================

SEVSEG_SCAN -- requirements
Module: sevseg_scan

Interface
REQ-001 Parameter NDIGITS, default 4, digit count; legal range 1..8.
REQ-002 Parameter DIV, default 2400, ON cycles per digit slot; legal minimum 1.
REQ-003 Parameter BLANK_CYCLES, default 4, anti-ghost dead cycles before each digit's ON phase; legal minimum 1.
REQ-004 Signal: clk  input  1  clock; all state updates on the rising edge.
REQ-005 Signal: reset  input  1  synchronous, active-low reset.
REQ-006 Signal: load  input  1  captures digits/dp/blank_lz into the shadow register when high.
REQ-007 Signal: digits  input  4*NDIGITS  hex nibbles; digit k is digits[4k+3:4k]; digit 0 is least significant.
REQ-008 Signal: dp  input  NDIGITS  decimal point request per digit, active-high.
REQ-009 Signal: blank_lz  input  1  leading-zero suppression enable.
REQ-010 Signal: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Signal: dp_n  output  1  decimal point, active-low.
REQ-012 Signal: an  output  NDIGITS  digit enables, active-low, at most one low at a time.
REQ-013 Signal: frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-014 seg, dp_n, an and frame_done SHALL be registered outputs.
REQ-015 Each digit slot SHALL be BLANK_CYCLES cycles with an all high, then DIV cycles with only an[k] low.
REQ-016 Slots SHALL run in order 0,1,...,NDIGITS-1, then wrap to 0; frame length = NDIGITS*(BLANK_CYCLES+DIV) cycles.
REQ-017 During the BLANK phase, seg SHALL be 7'h7F and dp_n SHALL be 1.
REQ-018 During digit k's ON phase, seg SHALL show the hex glyph of display nibble k, with dp_n = ~display dp[k].
REQ-019 Active-high glyphs for 0..F SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; seg is their bitwise inverse.
REQ-020 When blank_lz is set, every digit above digit 0 whose nibble and all higher nibbles are zero SHALL drive seg=7'h7F; dp_n is still driven per REQ-018.
REQ-021 Digit 0 SHALL never be suppressed.
REQ-022 load SHALL write the shadow register on the same edge; multiple loads within one frame: last wins.
REQ-023 Shadow-to-display transfer SHALL occur only at the frame boundary: the edge that starts digit 0's BLANK phase.
REQ-024 Mid-frame loads SHALL NOT change any glyph in the current frame (no tearing).
REQ-025 If load coincides with the frame-boundary edge, the newly loaded value SHALL be transferred directly, bypassing the shadow register.
REQ-026 frame_done SHALL be high for exactly the last ON cycle of digit NDIGITS-1, once per frame.
REQ-027 an SHALL never have two bits low in any cycle, including across wrap-around.

Reset
REQ-028 While reset is low at an edge, the block SHALL drive: seg=7'h7F, dp_n=1, an=all ones, frame_done=0, slot index 0, phase BLANK, counters 0, shadow and display registers 0.
REQ-029 Asserting reset mid-slot SHALL take effect on the next edge with no partial ON cycle.
REQ-030 After the first edge with reset high, the first slot SHALL be digit 0's BLANK phase; an[0] goes low after BLANK_CYCLES cycles.

Verification
Bench parameters: NDIGITS=4, DIV=3, BLANK_CYCLES=1 (frame = 16 cycles).
REQ-031 Slot sequencing: after reset release with no load, the an sequence SHALL be 1111 x1, 1110 x3, 1111 x1, 1101 x3, 1111 x1, 1011 x3, 1111 x1, 0111 x3, then repeat.
- frame_done SHALL pulse once every 16 cycles.
- All glyphs SHALL show "0" (seg=40).
REQ-032 Display data: load digits=16'h12AF, dp=4'b0010, blank_lz=0 mid-frame.
- The current frame SHALL be unchanged.
- Next frame: digit0 seg=0E, digit1 seg=08 with dp_n=0, digit2 seg=24, digit3 seg=79; dp_n=1 elsewhere.
REQ-033 Leading-zero suppression: load digits=16'h0040, blank_lz=1.
- digit3 and digit2 seg=7F; digit1 seg=19; digit0 seg=40.
- Then load digits=16'h0000: only digit0 lit, seg=40.
REQ-034 Load at the boundary:
- load 16'h0005 on the frame-boundary edge SHALL be shown in the frame that starts on that edge.
- Loads of 16'h0001 then 16'h0002 in one frame SHALL show 2 next frame.
REQ-035 Reset mid-ON phase of digit 2: on the next edge, an=1111, seg=7F, dp_n=1, frame_done=0.
- After release, the display register SHALL be 0000 and sequencing SHALL restart at digit 0's BLANK phase.
REQ-036 Every cycle of every test, the bench SHALL check that an has at most one zero bit, and that seg=7F and dp_n=1 whenever an is all ones.

Source files
------------

// File: rtl/sevseg_scan_if.sv
// rtl/sevseg_scan_if.sv - display data and drive bundle for the seven-segment scanner
// Purpose: groups the shadow-load request and the multiplexed LED drive into one port.
// Members:
//   load        - capture digits/dp/blank_lz into the shadow register
//   digits      - 4*NDIGITS hex nibbles, digit 0 in bits [3:0]
//   dp          - per-digit decimal point request, active-high
//   blank_lz    - leading-zero suppression enable
//   seg         - segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n        - decimal point, active-low, registered
//   an          - digit enables, active-low, registered
//   frame_done  - one-cycle pulse on the last ON cycle of the last digit
// Modports: master drives the data side, slave is the scanner.
interface sevseg_scan_if #(
    parameter int NDIGITS = 4
);
    logic                   load;
    logic [4*NDIGITS-1:0]   digits;
    logic [NDIGITS-1:0]     dp;
    logic                   blank_lz;
    logic [6:0]             seg;
    logic                   dp_n;
    logic [NDIGITS-1:0]     an;
    logic                   frame_done;

    modport master (
        output load, digits, dp, blank_lz,
        input  seg, dp_n, an, frame_done
    );

    modport slave (
        input  load, digits, dp, blank_lz,
        output seg, dp_n, an, frame_done
    );
endinterface

// File: rtl/sevseg_scan.sv
// rtl/sevseg_scan.sv - multiplexed seven-segment scanner with tear-free frame update
// Purpose: scans NDIGITS hex digits, each slot = BLANK_CYCLES dead cycles then DIV
// ON cycles; new data is staged in a shadow register and only reaches the display
// register at the frame boundary.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-low
//   bus    - sevseg_scan_if.slave (load/digits/dp/blank_lz in, seg/dp_n/an/frame_done out)
module sevseg_scan #(
    parameter int NDIGITS      = 4,
    parameter int DIV          = 2400,
    parameter int BLANK_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    sevseg_scan_if.slave   bus
);
    localparam int CMAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int DW   = 4 * NDIGITS;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    phase_t               phase, phase_nx;
    logic [SW-1:0]        slot, slot_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 run;
    logic                 boundary;

    logic [DW-1:0]        sh_digits, disp_digits, disp_digits_nx;
    logic [NDIGITS-1:0]   sh_dp, disp_dp, disp_dp_nx;
    logic                 sh_lz, disp_lz, disp_lz_nx;

    logic [NDIGITS-1:0]   zero_from;
    logic [3:0]           nib;
    logic [6:0]           seg_nx;
    logic                 dp_n_nx;
    logic [NDIGITS-1:0]   an_nx;
    logic                 fd_nx;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Slot sequencing. run is clear for the cycle after reset so that the first
    // edge with reset high is itself a frame boundary starting digit 0's BLANK.
    always_comb begin
        phase_nx = phase;
        slot_nx  = slot;
        cnt_nx   = cnt;
        boundary = 1'b0;
        if (!run) begin
            phase_nx = PH_BLANK;
            slot_nx  = '0;
            cnt_nx   = '0;
            boundary = 1'b1;
        end else if (phase == PH_BLANK) begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
                phase_nx = PH_ON;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end else begin
            if (cnt == CW'(DIV - 1)) begin
                phase_nx = PH_BLANK;
                cnt_nx   = '0;
                if (slot == SW'(NDIGITS - 1)) begin
                    slot_nx  = '0;
                    boundary = 1'b1;
                end else begin
                    slot_nx = slot + SW'(1);
                end
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end

    // A load on the boundary edge bypasses the shadow so it shows this frame.
    always_comb begin
        disp_digits_nx = disp_digits;
        disp_dp_nx     = disp_dp;
        disp_lz_nx     = disp_lz;
        if (boundary) begin
            if (bus.load) begin
                disp_digits_nx = bus.digits;
                disp_dp_nx     = bus.dp;
                disp_lz_nx     = bus.blank_lz;
            end else begin
                disp_digits_nx = sh_digits;
                disp_dp_nx     = sh_dp;
                disp_lz_nx     = sh_lz;
            end
        end
    end

    // Outputs are computed from next state so the registered drive lines up with
    // the phase it belongs to. zero_from[k]: nibble k and all above it are zero.
    always_comb begin
        zero_from = '0;
        zero_from[NDIGITS-1] = (disp_digits_nx[DW-1 -: 4] == 4'h0);
        for (int k = NDIGITS - 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (disp_digits_nx[4*k +: 4] == 4'h0);
        end
        nib     = disp_digits_nx[{slot_nx, 2'b00} +: 4];
        seg_nx  = 7'h7F;
        dp_n_nx = 1'b1;
        an_nx   = '1;
        fd_nx   = 1'b0;
        if (phase_nx == PH_ON) begin
            an_nx[slot_nx] = 1'b0;
            dp_n_nx        = ~disp_dp_nx[slot_nx];
            if (!(disp_lz_nx && (slot_nx != '0) && zero_from[slot_nx])) begin
                seg_nx = ~glyph(nib);
            end
            fd_nx = (slot_nx == SW'(NDIGITS - 1)) && (cnt_nx == CW'(DIV - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase          <= PH_BLANK;
            slot           <= '0;
            cnt            <= '0;
            run            <= 1'b0;
            sh_digits      <= '0;
            sh_dp          <= '0;
            sh_lz          <= 1'b0;
            disp_digits    <= '0;
            disp_dp        <= '0;
            disp_lz        <= 1'b0;
            bus.seg        <= 7'h7F;
            bus.dp_n       <= 1'b1;
            bus.an         <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            run            <= 1'b1;
            phase          <= phase_nx;
            slot           <= slot_nx;
            cnt            <= cnt_nx;
            if (bus.load) begin
                sh_digits <= bus.digits;
                sh_dp     <= bus.dp;
                sh_lz     <= bus.blank_lz;
            end
            disp_digits    <= disp_digits_nx;
            disp_dp        <= disp_dp_nx;
            disp_lz        <= disp_lz_nx;
            bus.seg        <= seg_nx;
            bus.dp_n       <= dp_n_nx;
            bus.an         <= an_nx;
            bus.frame_done <= fd_nx;
        end
    end
endmodule
